uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// Each granted byte gets one start strobe, then waits for done or timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic                   busy,
    output logic                   uart_start,
    output logic [7:0]             uart_txin,
    input  logic                   uart_txdone
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [14:0] LP_TMAX = 15'(TIMEOUT - 1);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_err;
    logic               r_busy;
    logic               r_start;
    logic [7:0]         r_txin;
    logic [1:0]         r_last;
    logic [1:0]         r_win;
    logic [14:0]        r_cnt;

    state_t             w_nstate;
    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] w_ack;
    logic               w_err;
    logic               w_start;
    logic [7:0]         w_txin;
    logic [1:0]         w_last;
    logic [1:0]         w_win;
    logic [14:0]        w_cnt;
    logic [1:0]         w_sel;
    logic [1:0]         w_idx;
    logic               w_found;

    // Search starts just after the last winner and wraps
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_gnt    = r_gnt;
        w_ack    = '0;
        w_err    = 1'b0;
        w_start  = 1'b0;
        w_txin   = r_txin;
        w_last   = r_last;
        w_win    = r_win;
        w_cnt    = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nstate = GRANT;
                    w_win    = w_sel;
                    w_gnt    = NUM_REQ'(1) << w_sel;
                    w_txin   = req_data[{w_sel, 3'b000} +: 8];
                    w_start  = 1'b1;
                end
            end
            GRANT: begin
                w_nstate = WAIT;
                w_cnt    = '0;
            end
            WAIT: begin
                w_cnt = r_cnt + 15'd1;
                // Completion takes precedence over a coincident timeout
                if (uart_txdone) begin
                    w_nstate = RELEASE;
                    w_ack    = r_gnt;
                    w_gnt    = '0;
                end else if (r_cnt == LP_TMAX) begin
                    w_nstate = RELEASE;
                    w_err    = 1'b1;
                    w_gnt    = '0;
                end
            end
            RELEASE: begin
                w_nstate = IDLE;
                w_last   = r_win;
            end
            default: w_nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_txin  <= 8'h00;
            r_last  <= 2'd3;
            r_win   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            r_gnt   <= w_gnt;
            r_ack   <= w_ack;
            r_err   <= w_err;
            r_busy  <= (w_nstate != IDLE);
            r_start <= w_start;
            r_txin  <= w_txin;
            r_last  <= w_last;
            r_win   <= w_win;
            r_cnt   <= w_cnt;
        end
    end

    assign gnt        = r_gnt;
    assign ack        = r_ack;
    assign err        = r_err;
    assign busy       = r_busy;
    assign uart_start = r_start;
    assign uart_txin  = r_txin;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle table plus corner sequences.
module tb_uart_tx_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic        uart_start;
    logic [7:0]  uart_txin;
    logic        uart_txdone;

    int n_chk = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .uart_start (uart_start),
        .uart_txin  (uart_txin),
        .uart_txdone(uart_txdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       txd;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       err;
        logic       busy;
        logic       start;
        logic [7:0] txin;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'h0;
        uart_txdone = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    int starts;
    int n;
    bit seen;

    initial begin
        rst         = 1'b1;
        req         = 4'h0;
        req_data    = 32'h44A52211;
        uart_txdone = 1'b0;

        // rst req txd | gnt ack err busy start txin
        tv.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00});
        tv.push_back('{1'b0, 4'h4, 1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b1, 8'hA5});
        tv.push_back('{1'b0, 4'h4, 1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'hA5});
        tv.push_back('{1'b0, 4'h4, 1'b1, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 8'hA5});
        tv.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5});
        tv.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5});
        tv.push_back('{1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 8'h11});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'h11});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 8'h11});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h11});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1, 8'h22});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b0, 8'h22});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h0, 4'h2, 1'b0, 1'b1, 1'b0, 8'h22});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h22});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h4, 4'h0, 1'b0, 1'b1, 1'b1, 8'hA5});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 1'b0, 8'hA5});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h0, 4'h4, 1'b0, 1'b1, 1'b0, 8'hA5});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'hA5});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h8, 4'h0, 1'b0, 1'b1, 1'b1, 8'h44});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h8, 4'h0, 1'b0, 1'b1, 1'b0, 8'h44});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 8'h44});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h44});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 8'h11});
        tv.push_back('{1'b0, 4'hF, 1'b0, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 8'h11});
        tv.push_back('{1'b0, 4'hF, 1'b1, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 8'h11});
        tv.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h11});

        for (int i = 0; i < tv.size(); i++) begin
            rst         = tv[i].rst;
            req         = tv[i].req;
            uart_txdone = tv[i].txd;
            tick();
            chk($sformatf("v%0d gnt", i),   32'(gnt),        32'(tv[i].gnt));
            chk($sformatf("v%0d ack", i),   32'(ack),        32'(tv[i].ack));
            chk($sformatf("v%0d err", i),   32'(err),        32'(tv[i].err));
            chk($sformatf("v%0d busy", i),  32'(busy),       32'(tv[i].busy));
            chk($sformatf("v%0d start", i), 32'(uart_start), 32'(tv[i].start));
            chk($sformatf("v%0d txin", i),  32'(uart_txin),  32'(tv[i].txin));
        end

        // Timeout: err exactly TO cycles after WAIT entry
        do_reset();
        req = 4'h1;
        tick();
        tick();
        chk("to wait gnt", 32'(gnt), 32'h1);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 3 * TO && !seen; k++) begin
            tick();
            n++;
            if (ack != 4'h0) chk("to ack", 32'(ack), 32'h0);
            if (err) seen = 1'b1;
        end
        chk("to seen", 32'(seen), 32'h1);
        chk("to latency", 32'(n), 32'(TO));
        chk("to ack at err", 32'(ack), 32'h0);
        chk("to busy at err", 32'(busy), 32'h1);
        chk("to gnt at err", 32'(gnt), 32'h0);
        req = 4'h0;
        tick();
        chk("to err pulse", 32'(err), 32'h0);
        tick();
        chk("to busy low", 32'(busy), 32'h0);

        // Coincident done and timeout: done wins
        do_reset();
        req = 4'h1;
        tick();
        tick();
        for (int k = 0; k < TO - 1; k++) tick();
        uart_txdone = 1'b1;
        tick();
        chk("co ack", 32'(ack), 32'h1);
        chk("co err", 32'(err), 32'h0);
        uart_txdone = 1'b0;
        req = 4'h0;
        tick();
        chk("co err late", 32'(err), 32'h0);
        chk("co busy", 32'(busy), 32'h0);

        // Reset mid-byte
        do_reset();
        req = 4'h4;
        tick();
        chk("rm gnt", 32'(gnt), 32'h4);
        tick();
        rst = 1'b1;
        req = 4'h6;
        uart_txdone = 1'b1;
        tick();
        chk("rm gnt0", 32'(gnt), 32'h0);
        chk("rm busy0", 32'(busy), 32'h0);
        chk("rm ack0", 32'(ack), 32'h0);
        chk("rm err0", 32'(err), 32'h0);
        rst = 1'b0;
        uart_txdone = 1'b0;
        tick();
        chk("rm regnt", 32'(gnt), 32'h2);
        chk("rm txin", 32'(uart_txin), 32'h22);

        // Dropped request during WAIT
        do_reset();
        starts = 0;
        req = 4'h8;
        tick();
        if (uart_start) starts++;
        chk("dr gnt", 32'(gnt), 32'h8);
        tick();
        if (uart_start) starts++;
        req = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (uart_start) starts++;
        end
        chk("dr held gnt", 32'(gnt), 32'h8);
        uart_txdone = 1'b1;
        tick();
        if (uart_start) starts++;
        chk("dr ack", 32'(ack), 32'h8);
        uart_txdone = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (uart_start) starts++;
        end
        chk("dr starts", 32'(starts), 32'h1);
        chk("dr busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
